am2902_chain: RTL
=================

// Module: am2902_chain
// PURPOSE
//  Parametrised successor to the Am2902 look-ahead carry generator, GROUPS wide.
//  Adds multi-beat carry chaining: the carry-out of one beat feeds the carry-in
//  of the next, for multi-precision ALU sequences. Inputs use valid/ready, the
//  output is registered. Sits between the ALU slice G/P outputs and microsequencer flags.
// PARAMETERS
//  GROUPS  4  number of G/P group input pairs (legal 2..16)
// PORTS
//  clk          in   1       clock, rising edge
//  nreset       in   1       asynchronous reset, active-low
//  in_valid     in   1       input beat valid
//  in_ready     out  1       input beat accepted when in_valid & in_ready
//  in_ng        in   GROUPS  generate terms, active-low, bit i = group i
//  in_np        in   GROUPS  propagate terms, active-low
//  in_cin       in   1       external carry-in, used on first beat only
//  in_first     in   1       beat opens a new chain
//  in_last      in   1       beat closes the chain
//  out_valid    out  1       result register valid
//  out_ready    in   1       consumer accepts result
//  out_cout     out  GROUPS  bit i = carry out of group i; [GROUPS-1] = full carry-out
//  out_ng       out  1       group generate, active-low
//  out_np       out  1       group propagate, active-low
//  out_cused    out  1       carry-in actually applied to this beat
//  out_last     out  1       copy of in_last of this beat
//  out_seq_err  out  1       beat broke first/last framing
// BEHAVIOUR
//  Carry: C[-1]=cused; C[i] = !ng[i] | (!np[i] & C[i-1]), for i = 0..GROUPS-1.
//  Group: G = C[GROUPS-1] evaluated with C[-1]=0. P = &(~np). out_ng=!G, out_np=!P.
//  cused = in_first ? in_cin : chain_c. chain_c register <= C[GROUPS-1] on accept.
//  If in_last is set, chain_c <= 0 instead.
//  FSM has two states, IDLE and CHAIN. Reset state is IDLE.
//   IDLE + first & !last -> CHAIN. IDLE + first & last -> IDLE (single-beat chain).
//   CHAIN + !first & last -> IDLE. CHAIN + !first & !last -> CHAIN.
//   IDLE + !first: orphan beat. cused = chain_c (=0). seq_err=1.
//     Next state: CHAIN if !last, IDLE if last.
//   CHAIN + first: abandoned chain. New chain starts with in_cin. seq_err=1.
//     Next state: IDLE if last, else CHAIN.
//  Latency: a beat accepted at edge k appears with out_valid=1 after edge k.
//  Handshake: in_ready = !out_valid | out_ready, combinational.
//   The output register holds its value while out_valid & !out_ready.
//   out_valid falls after the accepting edge if there is no new beat.
//   Accept and drain in the same cycle sustains 1 beat/clk.
//  Reset (async, any time, including mid-chain): FSM=IDLE, chain_c=0, out_valid=0.
//   out_cout=0, out_ng=1, out_np=1, out_cused=0, out_last=0, out_seq_err=0.
//   A partial chain is discarded. The next beat without first is an orphan.
//  in_ng/in_np/in_cin/in_first/in_last are ignored when !in_valid or !in_ready.
// CONFIGURATION
//  AM2902_BEAT_COUNT_EN defined: adds output port out_beat [7:0].
//   out_beat = 1-based index of this beat in its chain. It is 1 on a first or
//   orphan beat and saturates at 255. Its counter resets to 0 asynchronously.
//  Not defined: the port and the counter are absent. Other behaviour is identical.
// TESTING (GROUPS=4)
//  Reset: hold nreset=0 -> out_valid=0, out_cout=0000, out_ng=1, out_np=1, in_ready=1.
//  Single beat: first=last=1, ng=1111, np=0000, cin=1, out_ready=1
//   -> next cycle out_cout=1111, out_np=0, out_ng=1, cused=1, seq_err=0.
//  Chain of 3:
//   beat1: first, ng=0111, np=1111, cin=0 -> cout=1000, out_ng=0.
//   beat2: ng=1111, np=0000 -> cused=1, cout=1111.
//   beat3: last, ng=1111, np=1111 -> cused=1, cout=0000.
//   Then the FSM is IDLE and chain_c=0.
//  Backpressure: beat accepted, out_ready=0 for 3 clks, in_valid=1
//   -> in_ready=0, outputs frozen. out_ready=1 -> next beat accepted the same cycle.
//  Framing:
//   Orphan beat (no first, in IDLE, cin=1, np=0000, ng=1111) -> cused=0, seq_err=1.
//   first while in CHAIN -> seq_err=1, cused=in_cin.
//  Reset mid-chain after beat1 of a 3-beat chain, then a beat without first
//   -> seq_err=1, cused=0.

Source files
------------

// File: rtl/am2902_chain.sv
// GROUPS-wide Am2902-style look-ahead carry generator with multi-beat carry chaining.
// Define AM2902_BEAT_COUNT_EN to add the out_beat chain-position output.
module am2902_chain #(
  parameter int GROUPS = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GROUPS-1:0] in_ng,
  input  logic [GROUPS-1:0] in_np,
  input  logic              in_cin,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GROUPS-1:0] out_cout,
  output logic              out_ng,
  output logic              out_np,
  output logic              out_cused,
  output logic              out_last,
  output logic              out_seq_err
`ifdef AM2902_BEAT_COUNT_EN
  ,
  output logic [7:0]        out_beat
`endif
);

  typedef enum logic {IDLE, CHAIN} state_t;

  state_t            state_reg, state_next;
  logic              chain_c_reg;
  logic              accept;
  logic              cused;
  logic              seq_err;
  logic [GROUPS-1:0] cout;
  logic [GROUPS-1:0] gen_cout;

  // Ripple form of the look-ahead equations; inputs are active-low.
  function automatic logic [GROUPS-1:0] carry_chain(input logic [GROUPS-1:0] ng,
                                                    input logic [GROUPS-1:0] np,
                                                    input logic              c_in);
    logic [GROUPS-1:0] res;
    logic              c;
    res = '0;
    c   = c_in;
    for (int i = 0; i < GROUPS; i++) begin
      c      = ~ng[i] | (~np[i] & c);
      res[i] = c;
    end
    return res;
  endfunction

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign cused    = in_first ? in_cin : chain_c_reg;
  assign cout     = carry_chain(in_ng, in_np, cused);
  assign gen_cout = carry_chain(in_ng, in_np, 1'b0);

  always_comb begin
    state_next = state_reg;
    seq_err    = 1'b0;
    case (state_reg)
      IDLE:    seq_err = ~in_first;
      CHAIN:   seq_err = in_first;
      default: seq_err = 1'b0;
    endcase
    // Every framing case resolves the same way: last closes, otherwise chain continues.
    if (accept) begin
      state_next = in_last ? IDLE : CHAIN;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      chain_c_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        chain_c_reg <= in_last ? 1'b0 : cout[GROUPS-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid   <= 1'b0;
      out_cout    <= '0;
      out_ng      <= 1'b1;
      out_np      <= 1'b1;
      out_cused   <= 1'b0;
      out_last    <= 1'b0;
      out_seq_err <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_cout    <= cout;
      out_ng      <= ~gen_cout[GROUPS-1];
      out_np      <= ~(&(~in_np));
      out_cused   <= cused;
      out_last    <= in_last;
      out_seq_err <= seq_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef AM2902_BEAT_COUNT_EN
  // First and orphan beats both start a fresh count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_beat <= 8'd0;
    end else if (accept) begin
      if (in_first || state_reg == IDLE) begin
        out_beat <= 8'd1;
      end else if (out_beat != 8'd255) begin
        out_beat <= out_beat + 8'd1;
      end
    end
  end
`endif

endmodule
